// File: rtl/sensor_spi_responder.sv
// SPI mode-0 register responder: 24-bit frames (8-bit command, 16-bit data)
// sampled on clk through synchronizers; exposes temp snapshot, config and ID.
module sensor_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVICE_ID   = 8'hA5,
  parameter logic [15:0] CFG_RESET   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_neg,
  input  logic        cs_n,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] temp_value,
  output logic [15:0] config_reg,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync, vld;
  logic cs_q, sck_q, armed;
  logic cs_s, sck_s, mosi_s, primed;
  logic cs_fall, cs_rise, sck_rise, sck_fall, start;

  state_t            state, state_d;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [14:0]       rx, rx_d;
  logic [WORD_W-1:0] tx, tx_d, temp_snap, temp_snap_d, config_d, rd_word_c;
  logic [7:0]        cmd_c;
  logic cmd_rd, cmd_rd_d, cmd_wr_cfg, cmd_wr_cfg_d, armed_d;
  logic miso_d, busy_d, frame_done_d, frame_err_d;

  // Input synchronizers; vld marks when the chain holds only post-reset samples
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      vld       <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      vld       <= {vld[SYNC_STAGES-2:0], 1'b1};
      cs_q      <= cs_s;
      sck_q     <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign primed   = vld[SYNC_STAGES-1];
  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;
  assign sck_rise = ~sck_q & sck_s;
  assign sck_fall = sck_q & ~sck_s;
  // A frame may only start once cs_n has genuinely been seen high since reset
  assign start    = cs_fall & armed;
  assign cmd_c    = {rx[6:0], mosi_s};

  always_comb begin
    rd_word_c = '0;
    case (cmd_c[6:0])
      7'h00:   rd_word_c = temp_snap;
      7'h01:   rd_word_c = config_reg;
      7'h02:   rd_word_c = {8'h00, DEVICE_ID};
      default: rd_word_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx         <= '0;
      tx         <= '0;
      temp_snap  <= '0;
      config_reg <= CFG_RESET;
      cmd_rd     <= 1'b0;
      cmd_wr_cfg <= 1'b0;
      armed      <= 1'b0;
      miso       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      rx         <= rx_d;
      tx         <= tx_d;
      temp_snap  <= temp_snap_d;
      config_reg <= config_d;
      cmd_rd     <= cmd_rd_d;
      cmd_wr_cfg <= cmd_wr_cfg_d;
      armed      <= armed_d;
      miso       <= miso_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      frame_err  <= frame_err_d;
    end
  end

  // Next-state logic; cs_n rising edge takes priority over any same-cycle sck edge
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    rx_d         = rx;
    tx_d         = tx;
    temp_snap_d  = temp_snap;
    config_d     = config_reg;
    cmd_rd_d     = cmd_rd;
    cmd_wr_cfg_d = cmd_wr_cfg;
    armed_d      = armed | (primed & cs_s);
    miso_d       = miso;
    busy_d       = busy;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state)
      IDLE: begin
        miso_d = 1'b0;
        if (start) begin
          state_d     = CMD;
          bit_cnt_d   = '0;
          tx_d        = '0;
          temp_snap_d = temp_value;
          busy_d      = 1'b1;
        end
      end
      CMD: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          miso_d      = 1'b0;
        end else if (sck_rise) begin
          rx_d      = {rx[13:0], mosi_s};
          bit_cnt_d = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(7)) begin
            state_d      = DATA;
            cmd_rd_d     = cmd_c[7];
            cmd_wr_cfg_d = ~cmd_c[7] & (cmd_c[6:0] == 7'h01);
            tx_d         = cmd_c[7] ? rd_word_c : '0;
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          miso_d      = 1'b0;
        end else if (sck_rise) begin
          rx_d      = {rx[13:0], mosi_s};
          bit_cnt_d = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(23)) begin
            state_d = DONE;
            miso_d  = 1'b0;
            if (cmd_wr_cfg) config_d = {rx, mosi_s};
          end
        end else if (sck_fall && cmd_rd) begin
          miso_d = tx[15];
          tx_d   = {tx[14:0], 1'b0};
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sensor_spi_responder.sv
// Directed bench for sensor_spi_responder: read map, writes, aborts,
// temperature snapshot and mid-frame reset, sck at clk/10.
module tb_sensor_spi_responder;

  logic        clk = 1'b0;
  logic        rst_neg, cs_n, sck, mosi, miso;
  logic [15:0] temp_value, config_reg;
  logic        busy, frame_done, frame_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;

  sensor_spi_responder #(
    .SYNC_STAGES(2), .DEVICE_ID(8'hA5), .CFG_RESET(16'h0000)
  ) dut (
    .clk(clk), .rst_neg(rst_neg), .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .miso(miso), .temp_value(temp_value), .config_reg(config_reg),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (frame_done && frame_err) both_cnt++;
  end

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  // One SPI frame of nbits; optional temp change or reset pulse at a bit index
  task automatic spi_xfer(input logic [7:0] cmd, input logic [15:0] data,
                          input int nbits, input int chg_at, input logic [15:0] chg_val,
                          input int rst_at, output logic [15:0] rd, output int miso_bad);
    logic [23:0] frame;
    frame = {cmd, data};
    rd = '0;
    miso_bad = 0;
    cs_n = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_neg = 1'b0;
        repeat (2) @(negedge clk);
        rst_neg = 1'b1;
        repeat (4) @(negedge clk);
        return;
      end
      if (i == chg_at) temp_value = chg_val;
      mosi = frame[23-i];
      half();
      sck = 1'b1;
      if (i >= 8) rd[23-i] = miso;
      else if (miso !== 1'b0) miso_bad++;
      half();
      sck = 1'b0;
    end
    half();
    if (miso !== 1'b0) miso_bad++;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (config_reg !== 16'h0000) begin errors++; $display("FAIL reset_cfg got=%h exp=0000", config_reg); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", frame_err); end
  endtask

  task automatic test_busy();
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_high got=%b exp=1", busy); end
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_low got=%b exp=0", busy); end
  endtask

  task automatic test_temp_read();
    logic [15:0] rd; int bad, d0, e0;
    temp_value = 16'h0C80;
    d0 = done_cnt; e0 = err_cnt;
    spi_xfer(8'h80, 16'h0000, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (rd !== 16'h0C80) begin errors++; $display("FAIL temp_read got=%h exp=0c80", rd); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL temp_miso_idle got=%0d exp=0", bad); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL temp_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL temp_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; int bad, d0;
    d0 = done_cnt;
    spi_xfer(8'h01, 16'h1234, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (config_reg !== 16'h1234) begin errors++; $display("FAIL wr_cfg got=%h exp=1234", config_reg); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wr_miso got=%0d exp=0", bad); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL wr_miso_data got=%h exp=0000", rd); end
    spi_xfer(8'h81, 16'h0000, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL rd_cfg got=%h exp=1234", rd); end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL wr_rd_done got=%0d exp=2", done_cnt - d0); end
  endtask

  task automatic test_id_reads();
    logic [15:0] rd; int bad;
    spi_xfer(8'h82, 16'h0000, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (rd !== 16'h00A5) begin errors++; $display("FAIL rd_id got=%h exp=00a5", rd); end
    spi_xfer(8'h85, 16'hFFFF, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rd_unmapped got=%h exp=0000", rd); end
    spi_xfer(8'h05, 16'hFFFF, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (config_reg !== 16'h1234) begin errors++; $display("FAIL wr_unmapped got=%h exp=1234", config_reg); end
  endtask

  task automatic test_abort();
    logic [15:0] rd; int bad, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    spi_xfer(8'h01, 16'hBEEF, 12, -1, 16'h0, -1, rd, bad);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL abort_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (config_reg !== 16'h1234) begin errors++; $display("FAIL abort_cfg got=%h exp=1234", config_reg); end
    spi_xfer(8'h81, 16'h0000, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL abort_next got=%h exp=1234", rd); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL abort_next_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_temp_change();
    logic [15:0] rd; int bad;
    temp_value = 16'h0C80;
    spi_xfer(8'h80, 16'h0000, 24, 10, 16'h0D00, -1, rd, bad);
    checks++; if (rd !== 16'h0C80) begin errors++; $display("FAIL temp_snap got=%h exp=0c80", rd); end
    spi_xfer(8'h80, 16'h0000, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (rd !== 16'h0D00) begin errors++; $display("FAIL temp_new got=%h exp=0d00", rd); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; int bad, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    spi_xfer(8'h01, 16'h5678, 24, -1, 16'h0, 15, rd, bad);
    checks++; if (config_reg !== 16'h0000) begin errors++; $display("FAIL rst_cfg got=%h exp=0000", config_reg); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso got=%b exp=0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    // cs_n still low from before the reset: this frame must be ignored
    spi_xfer(8'h01, 16'hBEEF, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (config_reg !== 16'h0000) begin errors++; $display("FAIL rst_nostart_cfg got=%h exp=0000", config_reg); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rst_err got=%0d exp=0", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rst_nostart_done got=%0d exp=0", done_cnt - d0); end
    spi_xfer(8'h01, 16'h5A5A, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (config_reg !== 16'h5A5A) begin errors++; $display("FAIL rst_next_cfg got=%h exp=5a5a", config_reg); end
    spi_xfer(8'h81, 16'h0000, 24, -1, 16'h0, -1, rd, bad);
    checks++; if (rd !== 16'h5A5A) begin errors++; $display("FAIL rst_next_rd got=%h exp=5a5a", rd); end
  endtask

  initial begin
    rst_neg = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; temp_value = 16'h0000;
    repeat (3) @(negedge clk);
    test_reset();
    rst_neg = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    test_busy();
    test_temp_read();
    test_write_read();
    test_id_reads();
    test_abort();
    test_temp_change();
    test_reset_mid();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_err_overlap got=%0d exp=0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_spi_responder.md
SENSOR_SPI_RESPONDER -- requirements
Module: sensor_spi_responder

Interface
REQ-001 Parameters SHALL be:
- SYNC_STAGES, 2, synchronizer depth for cs_n, sck and mosi.
- DEVICE_ID, 8'hA5, value returned in the low byte of register 0x02.
- CFG_RESET, 16'h0000, reset value of the config register.

REQ-002 Ports SHALL be:
- clk  in  1  system clock, 50 MHz.
- rst_neg  in  1  asynchronous active-low reset.
- cs_n  in  1  SPI chip select from the initiator, active low.
- sck  in  1  SPI clock from the initiator, SPI mode 0.
- mosi  in  1  serial data from the initiator.
- miso  out  1  serial data to the initiator.
- temp_value  in  16  live temperature word supplied by the sensor model.
- config_reg  out  16  current config register contents.
- busy  out  1  high while the synchronized cs_n is low.
- frame_done  out  1  one-cycle pulse when a complete frame ends.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

Function
REQ-003 Input sampling:
- cs_n, sck and mosi SHALL pass through SYNC_STAGES flip-flops on clk.
- All edge detection SHALL use the synchronized signals only.
- sck SHALL be supported up to clk/8.

REQ-004 The FSM SHALL have states IDLE, CMD, DATA and DONE.

REQ-005 IDLE -> CMD on synchronized cs_n falling edge:
- bit counter cleared.
- temp_value snapshotted into temp_snap in the same clk cycle; a simultaneous temp_value change is captured as its new value.

REQ-006 Sampling and shifting:
- MOSI SHALL be sampled on each synchronized sck rising edge, MSB first.
- MISO SHALL update on each synchronized sck falling edge.

REQ-007 Frame format is 24 bits:
- bits 0-7: command byte. cmd[7] = 1 means read, 0 means write. cmd[6:0] is the address.
- bits 8-23: 16-bit data word, MSB first.

REQ-008 On the 8th rising edge the command SHALL be latched and the FSM SHALL enter DATA. For a read, the 16-bit read word SHALL be loaded into the transmit shift register.

REQ-009 Read map:
- 0x00 returns temp_snap.
- 0x01 returns config_reg.
- 0x02 returns {8'h00, DEVICE_ID}.
- Any other address returns 16'h0000.

REQ-010 Read timing: the falling edge following the 8th rising edge SHALL drive read bit 15 on miso. Each subsequent falling edge SHALL shift out the next bit down to bit 0.

REQ-011 Outside read data bits, miso SHALL be 0. This covers cs_n high, the command phase, and write frames.

REQ-012 Write:
- A write to 0x01 SHALL update config_reg on the 24th rising edge.
- Writes to any other address SHALL be discarded without side effects.

REQ-013 After the 24th rising edge the FSM SHALL enter DONE. Further sck edges SHALL be ignored and miso SHALL stay 0.

REQ-014 Synchronized cs_n rising edge:
- In DONE: pulse frame_done for 1 clk and go to IDLE.
- In CMD or DATA: pulse frame_err for 1 clk, perform no write, and go to IDLE.

REQ-015 A cs_n rising edge and an sck rising edge detected in the same clk cycle SHALL be treated as the cs_n edge only; that sck edge is discarded.

REQ-016 frame_done and frame_err SHALL never be asserted in the same cycle.

REQ-017 busy SHALL be 1 from the cycle after the synchronized cs_n falling edge through the cycle of the synchronized cs_n rising edge.

Reset
REQ-018 rst_neg low SHALL asynchronously force:
- FSM to IDLE.
- miso, busy, frame_done and frame_err to 0.
- bit counter, shift registers and temp_snap to 0.
- config_reg to CFG_RESET.
- all synchronizer flops to their idle levels: cs_n 1, sck 0, mosi 0.

REQ-019 Reset asserted mid-frame SHALL abort the frame without a frame_err pulse.

REQ-020 After reset deassertion with cs_n already low, no frame SHALL start until cs_n has been seen high and then low again.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- temp_value=16'h0C80, frame with cmd 8'h80 at sck=clk/10 -> miso carries 0x0C80 MSB first; frame_done pulses once.
- Write frame cmd 8'h01, data 16'h1234, then read frame cmd 8'h81 -> config_reg=16'h1234 after the 24th edge; the read returns 0x1234.
- Read frame cmd 8'h82 -> 0x00A5. Read frame cmd 8'h85 -> 0x0000.
- Write frame to 0x01 with cs_n raised after 12 bits -> frame_err pulses; config_reg unchanged; next full frame works normally.
- temp_value changes from 0x0C80 to 0x0D00 mid-frame on a 0x00 read -> miso still returns 0x0C80.
- rst_neg pulsed low at bit 15 of a write -> config_reg=CFG_RESET; no frame_err; miso 0; next frame after cs_n toggles high then low completes correctly.
